// File: rtl/leaf_skid_stage_if.sv
// Valid/ready bundle for leaf_skid_stage.
// The slave side is the stage; the master side drives it.
interface leaf_skid_stage_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [11:0]       out_tag;
  logic [15:0]       xfer_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_tag, xfer_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_tag, xfer_count
  );
endinterface

// File: rtl/leaf_skid_stage.sv
// Two-entry registered valid/ready stage.
// Stamps each word with a sequence number and counts output transfers.
module leaf_skid_stage #(
  parameter int          DATA_W  = 8,
  parameter logic [3:0]  NODE_ID = 4'd0
) (
  input logic               clk,
  input logic               rst_n,
  leaf_skid_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [7:0]        seq;
  } ent_t;

  ent_t        head, tail;
  ent_t        head_n, tail_n;
  ent_t        inc;
  logic [1:0]  occ, occ_n;
  logic [7:0]  seq, seq_n;
  logic [15:0] cnt, cnt_n;
  logic        rdy, vld;
  logic        push, pop;

  always_comb begin
    push   = bus.in_valid && rdy;
    pop    = vld && bus.out_ready;
    inc    = '{data: bus.in_data, seq: seq};
    head_n = head;
    tail_n = tail;
    occ_n  = occ;
    unique case (1'b1)
      push && !pop: begin
        if (occ == 2'd0) head_n = inc;
        else             tail_n = inc;
        occ_n = occ + 2'd1;
      end
      pop && !push: begin
        head_n = tail;
        occ_n  = occ - 2'd1;
      end
      push && pop: begin
        // Full-and-both cannot happen: rdy is low at occ 2.
        if (occ == 2'd1) begin
          head_n = inc;
        end else begin
          head_n = tail;
          tail_n = inc;
        end
      end
      default: ;
    endcase
    seq_n = push ? seq + 8'd1 : seq;
    cnt_n = (pop && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
      seq  <= 8'd0;
      cnt  <= 16'd0;
      rdy  <= 1'b1;
      vld  <= 1'b0;
    end else begin
      head <= head_n;
      tail <= tail_n;
      occ  <= occ_n;
      seq  <= seq_n;
      cnt  <= cnt_n;
      rdy  <= (occ_n < 2'd2);
      vld  <= (occ_n != 2'd0);
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = vld;
  assign bus.out_data   = head.data;
  assign bus.out_tag    = {NODE_ID, head.seq};
  assign bus.xfer_count = cnt;

endmodule

// File: tb/tb_leaf_skid_stage.sv
// Randomized bench for leaf_skid_stage.
// Checks every cycle against a queue-based reference model.
module tb_leaf_skid_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  leaf_skid_stage_if #(.DATA_W(8)) bus ();

  leaf_skid_stage #(
    .DATA_W (8),
    .NODE_ID(4'd3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [7:0] s;
    int         n;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_seq;
  int          m_acc;
  int          m_cnt;
  bit          chk_en = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
    if (q.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].d));
      chk("out_tag", 32'(bus.out_tag), {20'h0, 4'd3, q[0].s});
      if (q[0].n == 256)
        chk("seq_255", 32'(bus.out_tag[7:0]), 32'hFF);
      if (q[0].n == 257)
        chk("seq_wrap", 32'(bus.out_tag[7:0]), 32'h00);
    end
  endtask

  task automatic cycle();
    bit         rs, iv, ordy, push, pop;
    logic [7:0] id;
    @(negedge clk);
    if (chk_en) check_outputs();
    rs   = rst_n;
    iv   = bus.in_valid;
    ordy = bus.out_ready;
    id   = bus.in_data;
    @(posedge clk);
    if (!rs) begin
      q.delete();
      m_seq = 8'd0;
      m_acc = 0;
      m_cnt = 0;
    end else begin
      push = iv && (q.size() < 2);
      pop  = ordy && (q.size() > 0);
      if (pop) begin
        void'(q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (push) begin
        m_acc++;
        q.push_back('{d: id, s: m_seq, n: m_acc});
        m_seq = m_seq + 8'd1;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, logic [7:0] d, bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  logic [7:0] held;

  initial begin
    m_seq = 8'd0;
    m_acc = 0;
    m_cnt = 0;
    rst_n = 1'b0;
    drive(1'b1, 8'hAA, 1'b0);
    cycle();
    chk_en = 1'b1;
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h300);
    cycle();
    cycle();
    rst_n = 1'b1;

    // streaming
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      cycle();
      chk("stream_data", 32'(bus.out_data), 32'(i));
      chk("stream_tag", 32'(bus.out_tag), 32'h300 + 32'(i - 1));
    end
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    cycle();
    chk("stream_cnt", 32'(bus.xfer_count), 32'd5);

    // backpressure
    drive(1'b1, 8'h10, 1'b0);
    cycle();
    drive(1'b1, 8'h11, 1'b0);
    cycle();
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 8'h12, 1'b0);
    cycle();
    held = bus.out_data;
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", 32'(bus.out_data), 32'(held));
    end
    chk("bp_head", 32'(bus.out_data), 32'h10);
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    chk("bp_second", 32'(bus.out_data), 32'h11);
    chk("bp_recover", 32'(bus.in_ready), 32'd1);
    cycle();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // occ=1 simultaneous push/pop
    drive(1'b1, 8'h40, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 1'b1);
      cycle();
      chk("occ1_size", 32'(q.size()), 32'd1);
    end

    // general random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom));
      cycle();
    end

    // mid-operation reset with occ=2
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    cycle();
    drive(1'b1, 8'h55, 1'b0);
    cycle();
    drive(1'b1, 8'h66, 1'b0);
    cycle();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_rst_flush", 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 8'h77, 1'b1);
    cycle();
    chk("mid_rst_seq", 32'(bus.out_tag), 32'h300);
    chk("mid_rst_data", 32'(bus.out_data), 32'h77);

    // wrap and saturation
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      drive(1'b1, 8'($urandom), 1'b1);
      cycle();
    end
    chk("sat_cnt", 32'(bus.xfer_count), 32'hFFFF);
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    cycle();
    chk("sat_hold", 32'(bus.xfer_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
